// File: rtl/text_mode_renderer.sv
// Character-cell text renderer: coordinates -> text RAM -> font ROM -> CGA palette, 4-cycle latency.
// Optional feature: define BLINK_EN to use attr[7] as a blink flag driven by a 6-bit frame counter.
module text_mode_renderer #(
    parameter int unsigned BIT_WIDTH  = 12,
    parameter int unsigned BIT_HEIGHT = 11,
    parameter int unsigned COLS       = 80,
    parameter int unsigned ROWS       = 30,
    parameter int unsigned FONT_W     = 8,
    parameter int unsigned FONT_H     = 16,
    parameter int unsigned TB_AW      = 12
) (
    input  logic                  clk_pixel,
    input  logic                  reset_n,
    input  logic [BIT_WIDTH-1:0]  cx,
    input  logic [BIT_HEIGHT-1:0] cy,
    input  logic [11:0]           screen_start_x,
    input  logic [11:0]           screen_start_y,
    output logic [TB_AW-1:0]      tb_addr,
    input  logic [15:0]           tb_data,
    output logic [11:0]           font_addr,
    input  logic [7:0]            font_data,
    output logic [23:0]           rgb
);

    localparam int unsigned XW  = (BIT_WIDTH > 12) ? BIT_WIDTH : 12;
    localparam int unsigned YW  = (BIT_HEIGHT > 12) ? BIT_HEIGHT : 12;
    localparam int unsigned GXW = $clog2(FONT_W);
    localparam int unsigned GYW = $clog2(FONT_H);

    logic [XW-1:0]    cx_w, ssx_w, px;
    logic [YW-1:0]    cy_w, ssy_w, py;
    logic             in_text;
    logic [31:0]      col, row;

    logic [TB_AW-1:0] tb_addr_q, tb_addr_d;
    logic [GXW-1:0]   gx0_q, gx1_q;
    logic [GYW-1:0]   gy0_q;
    logic             v0_q, v1_q, v2_q;
    logic [11:0]      font_addr_q, font_addr_d;
    logic [7:0]       attr1_q, attr2_q;
    logic             bit2_q, bit2_d;
    logic [23:0]      rgb_q, rgb_d;
    logic [3:0]       fg, bg;

    assign cx_w  = XW'(cx);
    assign cy_w  = YW'(cy);
    assign ssx_w = XW'(screen_start_x);
    assign ssy_w = YW'(screen_start_y);
    assign px    = cx_w - ssx_w;
    assign py    = cy_w - ssy_w;

    // The start comparisons mask the wrapped subtraction in blanking.
    assign in_text = (cx_w >= ssx_w) && (cy_w >= ssy_w) &&
                     (px < XW'(COLS * FONT_W)) && (py < YW'(ROWS * FONT_H));

    assign col = 32'(px >> GXW);
    assign row = 32'(py >> GYW);

    function automatic logic [23:0] cga(input logic [3:0] idx);
        logic [23:0] c;
        case (idx)
            4'h0:    c = 24'h000000;
            4'h1:    c = 24'h0000AA;
            4'h2:    c = 24'h00AA00;
            4'h3:    c = 24'h00AAAA;
            4'h4:    c = 24'hAA0000;
            4'h5:    c = 24'hAA00AA;
            4'h6:    c = 24'hAA5500;
            4'h7:    c = 24'hAAAAAA;
            4'h8:    c = 24'h555555;
            4'h9:    c = 24'h5555FF;
            4'hA:    c = 24'h55FF55;
            4'hB:    c = 24'h55FFFF;
            4'hC:    c = 24'hFF5555;
            4'hD:    c = 24'hFF55FF;
            4'hE:    c = 24'hFFFF55;
            default: c = 24'hFFFFFF;
        endcase
        return c;
    endfunction

`ifdef BLINK_EN
    logic [5:0] frame_q;

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            frame_q <= '0;
        end else if (cx_w == '0 && cy_w == '0) begin
            frame_q <= frame_q + 6'd1;
        end
    end

    assign bg = {1'b0, attr2_q[6:4]};
    assign fg = (attr2_q[7] && frame_q[5]) ? bg : attr2_q[3:0];
`else
    assign bg = attr2_q[7:4];
    assign fg = attr2_q[3:0];
`endif

    always_comb begin
        tb_addr_d   = TB_AW'(row * COLS + col);
        font_addr_d = {tb_data[7:0], 4'(gy0_q)};
        bit2_d      = font_data[GXW'(FONT_W - 1) - gx1_q];
        rgb_d       = v2_q ? cga(bit2_q ? fg : bg) : 24'h000000;
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            tb_addr_q   <= '0;
            gx0_q       <= '0;
            gy0_q       <= '0;
            v0_q        <= 1'b0;
            font_addr_q <= '0;
            attr1_q     <= '0;
            gx1_q       <= '0;
            v1_q        <= 1'b0;
            bit2_q      <= 1'b0;
            attr2_q     <= '0;
            v2_q        <= 1'b0;
            rgb_q       <= '0;
        end else begin
            tb_addr_q   <= tb_addr_d;
            gx0_q       <= px[GXW-1:0];
            gy0_q       <= py[GYW-1:0];
            v0_q        <= in_text;
            font_addr_q <= font_addr_d;
            attr1_q     <= tb_data[15:8];
            gx1_q       <= gx0_q;
            v1_q        <= v0_q;
            bit2_q      <= bit2_d;
            attr2_q     <= attr1_q;
            v2_q        <= v1_q;
            rgb_q       <= rgb_d;
        end
    end

    assign tb_addr   = tb_addr_q;
    assign font_addr = font_addr_q;
    assign rgb       = rgb_q;

endmodule

// File: doc/text_mode_renderer.md
Name: text_mode_renderer

Overview:
Character-cell text renderer sitting between the HDMI timing core and its rgb input. It takes the pixel coordinates cx/cy from the HDMI core and fetches codepoint/attribute pairs from an external text-buffer RAM. It then fetches glyph rows from an external font ROM and emits a registered 24-bit rgb pixel at a fixed pipeline latency. The HDMI core consumes that rgb on the next clk_pixel edge.

Parameters:
BIT_WIDTH, 12, width of cx
BIT_HEIGHT, 11, width of cy
COLS, 80, text columns
ROWS, 30, text rows
FONT_W, 8, glyph width in pixels (fixed 8; one ROM byte per glyph row)
FONT_H, 16, glyph height in pixels (power of two)
TB_AW, 12, text-buffer address width

Ports:
clk_pixel  in  1  pixel clock
reset_n  in  1  asynchronous active-low reset
cx  in  BIT_WIDTH  current pixel x from HDMI core
cy  in  BIT_HEIGHT  current pixel y from HDMI core
screen_start_x  in  12  first visible x
screen_start_y  in  12  first visible y
tb_addr  out  TB_AW  text-buffer read address
tb_data  in  16  {attribute[7:0], codepoint[7:0]}, valid 1 cycle after tb_addr
font_addr  out  12  {codepoint[7:0], glyph_row[3:0]}
font_data  in  8  glyph row bits, MSB = leftmost pixel, valid 1 cycle after font_addr
rgb  out  24  {R,G,B} pixel to HDMI core

Behaviour:
- Single clock domain, clk_pixel.
- reset_n is asynchronous active-low. While low: rgb=0, tb_addr=0, font_addr=0, all pipeline valid bits=0, frame counter=0. Release is synchronous to clk_pixel.
- Definitions: px = cx - screen_start_x, py = cy - screen_start_y, both unsigned.
- in_text = (cx >= screen_start_x) && (cy >= screen_start_y) && px < COLS*FONT_W && py < ROWS*FONT_H.
- S0, cycle n:
  - col = px / FONT_W, row = py / FONT_H; both are shifts.
  - tb_addr <= row*COLS + col. The multiply is by a constant; the result is truncated to TB_AW.
  - Register gx = px % FONT_W, gy = py % FONT_H, and valid0 = in_text.
- S1, cycle n+1:
  - font_addr <= {tb_data[7:0], gy[3:0]}.
  - Register attribute = tb_data[15:8], gx, valid1.
- S2, cycle n+2:
  - bit = font_data[7 - gx].
  - Register bit, attribute, valid2.
- S3, cycle n+3:
  - rgb <= valid2 ? palette(bit ? attr[3:0] : attr[7:4]) : 24'h000000.
- Latency: rgb for coordinate (cx,cy) appears 4 clk_pixel edges after cx/cy is presented. The caller offsets screen_start_x by 4 to align.
- Palette: fixed 16-entry CGA table.
  - 0=000000, 1=0000AA, 2=00AA00, 3=00AAAA, 4=AA0000, 5=AA00AA, 6=AA5500, 7=AAAAAA.
  - 8=555555, 9=5555FF, A=55FF55, B=55FFFF, C=FF5555, D=FF55FF, E=FFFF55, F=FFFFFF.
- Frame counter: 6-bit, increments on the cycle where cx==0 && cy==0, wraps 63->0. It is unused unless BLINK_EN is defined.
- Boundaries:
  - Pixel exactly at px = COLS*FONT_W or py = ROWS*FONT_H is outside the text area -> black.
  - cx < screen_start_x (blanking) -> black. There is no wrap from the unsigned subtraction, because in_text is gated by the comparisons.
  - tb_addr and font_addr keep toggling with coordinates in blanking; their values there are don't-care and must not be relied upon.
  - Reset asserted mid-line: rgb is 0 immediately (async), with no partial pixels after release. The pipeline refills in 4 cycles.
- The pipeline is free-running: no stall or backpressure, one pixel per clock.

Optional Feature:
BLINK_EN
- Defined:
  - attr[7] is the blink flag; background = {1'b0, attr[6:4]}.
  - When attr[7]=1 and frame_counter[5]=1, the foreground is replaced by the background (glyph hidden).
  - Blink period is 64 frames: 32 frames visible, 32 frames hidden.
- Undefined: attr[7:4] is a full 4-bit background; the frame counter may be optimised away.

Test Plan:
1. Reset: hold reset_n=0 with random cx/cy -> rgb=000000, tb_addr=0, font_addr=0. Release, feed cx=screen_start_x, cy=screen_start_y -> tb_addr=0 after 1 edge.
2. Address map: screen_start=(0,0), cx=17, cy=35 -> tb_addr=2*80+2=162. Return tb_data=16'h1E41 -> next font_addr=12'h413.
3. Pixel colour: font_data=8'b1000_0000, gx=0, attr=8'h1E -> rgb=FFFF55 (yellow fg) at edge 4. With gx=1 -> rgb=0000AA (blue bg).
4. Bounds: cx=640 (px=640), cy=10 -> rgb=000000. cx=639, cy=479 with all-ones font_data, attr=8'h0F -> rgb=FFFFFF.
5. Latency/streaming: sweep cx 0..15 on one row, glyph 8'hAA, attr=8'h70 -> rgb alternates 000000/AAAAAA per pixel, starting exactly 4 cycles after cx=0.
6. BLINK_EN: attr=8'h8F, font_data=8'hFF. Frames 0-31 -> rgb=FFFFFF; frames 32-63 -> rgb=000000; frame 64 -> FFFFFF. Without the macro, same stimulus -> 555555 background never shown, always FFFFFF.
